// File: rtl/smi_header_inject_pf1.sv
// rtl/smi_header_inject_pf1.sv - prepends a header word to each flit-stream frame
module smi_header_inject_pf1 #(
    parameter int FlitWidth = 16,
    parameter int HeadWidth = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   headerReady,
    input  logic [HeadWidth*8-1:0] headerData,
    output logic                   headerStop,
    input  logic                   smiInReady,
    input  logic [7:0]             smiInEofc,
    input  logic [FlitWidth*8-1:0] smiInData,
    output logic                   smiInStop,
    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop
);

    // Bytes of an input flit that fit behind the header in the same output flit.
    localparam int FlitSplit = FlitWidth - HeadWidth;
    localparam int EofcMask  = 2 * FlitWidth - 1;

    localparam int FW = FlitWidth * 8;
    localparam int HW = HeadWidth * 8;
    localparam int SW = FlitSplit * 8;

    localparam logic [7:0] EofcMask8 = 8'(EofcMask);
    localparam logic [7:0] SplitEofc = 8'(FlitSplit);
    localparam logic [7:0] HeadEofc  = 8'(HeadWidth);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        TAIL = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input stages
    // ------------------------------------------------------------------
    logic          hdr_valid_q;
    logic [HW-1:0] hdr_data_q;
    logic          hdr_take;

    logic          fl_valid_q;
    logic [7:0]    fl_eofc_q;
    logic [FW-1:0] fl_data_q;
    logic          fl_take;

    // A full stage stops its producer only when the FSM is not draining it this cycle.
    assign headerStop = hdr_valid_q & ~hdr_take;
    assign smiInStop  = fl_valid_q & ~fl_take;

    // Header stage valid flag: refill whenever the stage is not stopped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdr_valid_q <= 1'b0;
        end else if (!headerStop) begin
            hdr_valid_q <= headerReady;
        end
    end

    // Header stage payload, captured alongside the valid flag.
    always_ff @(posedge clk) begin
        if (!headerStop && headerReady) begin
            hdr_data_q <= headerData;
        end
    end

    // Flit stage valid flag: refill whenever the stage is not stopped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fl_valid_q <= 1'b0;
        end else if (!smiInStop) begin
            fl_valid_q <= smiInReady;
        end
    end

    // Flit stage payload; eofc is masked on capture so later compares stay in range.
    always_ff @(posedge clk) begin
        if (!smiInStop && smiInReady) begin
            fl_eofc_q <= smiInEofc & EofcMask8;
            fl_data_q <= smiInData;
        end
    end

    // ------------------------------------------------------------------
    // Realignment state machine
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [HW-1:0] carry_q, carry_d;
    logic [7:0]    saved_eofc_q, saved_eofc_d;

    logic          buf_stop;
    logic          emit_valid;
    logic [7:0]    emit_eofc;
    logic [FW-1:0] emit_data;

    logic [SW-1:0] fl_low;
    logic [HW-1:0] fl_high;

    assign fl_low  = fl_data_q[SW-1:0];
    assign fl_high = fl_data_q[FW-1:SW];

    // Next-state, consume and emit decisions; nothing moves while the skid buffer is full.
    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        saved_eofc_d = saved_eofc_q;
        hdr_take     = 1'b0;
        fl_take      = 1'b0;
        emit_valid   = 1'b0;
        emit_eofc    = 8'd0;
        emit_data    = {fl_low, carry_q};

        case (state_q)
            IDLE: begin
                emit_data = {fl_low, hdr_data_q};
                if (hdr_valid_q && fl_valid_q && !buf_stop) begin
                    hdr_take = 1'b1;
                    fl_take  = 1'b1;
                end
            end
            COPY: begin
                if (fl_valid_q && !buf_stop) begin
                    fl_take = 1'b1;
                end
            end
            TAIL: begin
                emit_data = {{SW{1'b0}}, carry_q};
                emit_eofc = saved_eofc_q - SplitEofc;
                if (!buf_stop) begin
                    emit_valid = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any consumed flit leaves its upper bytes behind for the next output flit.
        if (fl_take) begin
            emit_valid   = 1'b1;
            carry_d      = fl_high;
            saved_eofc_d = fl_eofc_q;
            if (fl_eofc_q == 8'd0) begin
                emit_eofc = 8'd0;
                state_d   = COPY;
            end else if (fl_eofc_q <= SplitEofc) begin
                emit_eofc = fl_eofc_q + HeadEofc;
                state_d   = IDLE;
            end else begin
                emit_eofc = 8'd0;
                state_d   = TAIL;
            end
        end
    end

    // FSM state register; reset discards any partially emitted frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Carry bytes and saved eofc of the last consumed flit.
    always_ff @(posedge clk) begin
        carry_q      <= carry_d;
        saved_eofc_q <= saved_eofc_d;
    end

    // ------------------------------------------------------------------
    // Two-entry output skid buffer (entry 0 is the head)
    // ------------------------------------------------------------------
    logic          ob_v0_q, ob_v1_q;
    logic [7:0]    ob_e0_q, ob_e1_q;
    logic [FW-1:0] ob_d0_q, ob_d1_q;
    logic          ob_push;
    logic          ob_pop;

    assign buf_stop = ob_v0_q & ob_v1_q;
    assign ob_push  = emit_valid;
    assign ob_pop   = ob_v0_q & ~smiOutStop;

    assign smiOutReady = ob_v0_q;
    assign smiOutEofc  = ob_e0_q;
    assign smiOutData  = ob_d0_q;

    // Occupancy flags; entry 1 is only ever valid behind a valid entry 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ob_v0_q <= 1'b0;
            ob_v1_q <= 1'b0;
        end else if (ob_pop) begin
            ob_v0_q <= ob_v1_q | ob_push;
            ob_v1_q <= 1'b0;
        end else if (ob_push) begin
            if (ob_v0_q) begin
                ob_v1_q <= 1'b1;
            end else begin
                ob_v0_q <= 1'b1;
            end
        end
    end

    // Entry payloads: shift on pop, otherwise write into the first free entry.
    always_ff @(posedge clk) begin
        if (ob_pop) begin
            if (ob_v1_q) begin
                ob_e0_q <= ob_e1_q;
                ob_d0_q <= ob_d1_q;
            end else if (ob_push) begin
                ob_e0_q <= emit_eofc;
                ob_d0_q <= emit_data;
            end
        end else if (ob_push) begin
            if (ob_v0_q) begin
                ob_e1_q <= emit_eofc;
                ob_d1_q <= emit_data;
            end else begin
                ob_e0_q <= emit_eofc;
                ob_d0_q <= emit_data;
            end
        end
    end

endmodule

// File: tb/tb_smi_header_inject_pf1.sv
// tb/tb_smi_header_inject_pf1.sv - scoreboard bench for smi_header_inject_pf1
module tb_smi_header_inject_pf1;

    localparam int FW = 16;
    localparam int HW = 4;

    typedef struct packed {
        logic [7:0]      eofc;
        logic [FW*8-1:0] data;
    } flit_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            headerReady;
    logic [HW*8-1:0] headerData;
    logic            headerStop;
    logic            smiInReady;
    logic [7:0]      smiInEofc;
    logic [FW*8-1:0] smiInData;
    logic            smiInStop;
    logic            smiOutReady;
    logic [7:0]      smiOutEofc;
    logic [FW*8-1:0] smiOutData;
    logic            smiOutStop;

    smi_header_inject_pf1 #(.FlitWidth(FW), .HeadWidth(HW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .headerReady(headerReady),
        .headerData (headerData),
        .headerStop (headerStop),
        .smiInReady (smiInReady),
        .smiInEofc  (smiInEofc),
        .smiInData  (smiInData),
        .smiInStop  (smiInStop),
        .smiOutReady(smiOutReady),
        .smiOutEofc (smiOutEofc),
        .smiOutData (smiOutData),
        .smiOutStop (smiOutStop)
    );

    always #5 clk = ~clk;

    logic [HW*8-1:0] hdr_src[$];
    flit_t           flit_src[$];
    flit_t           exp_q[$];
    logic [7:0]      fb[$];

    int checks = 0;
    int errors = 0;
    bit hold = 1'b0;
    bit rand_stop = 1'b0;
    bit tput_mode = 1'b0;
    bit seen_first = 1'b0;
    int gap_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: header bytes followed by frame bytes, re-cut into 16-byte flits.
    task automatic add_frame(input logic [HW*8-1:0] h);
        int n, nin, nout, len, idx;
        logic [7:0] s[$];
        flit_t f;
        n = fb.size();
        nin = (n + FW - 1) / FW;
        for (int i = 0; i < nin; i++) begin
            f.data = '0;
            for (int j = 0; j < FW; j++) begin
                idx = i * FW + j;
                f.data[8*j +: 8] = (idx < n) ? fb[idx] : 8'hEE;
            end
            f.eofc = (i == nin - 1) ? 8'(n - FW * i) : 8'd0;
            flit_src.push_back(f);
        end
        for (int j = 0; j < HW; j++) s.push_back(h[8*j +: 8]);
        for (int j = 0; j < n; j++) s.push_back(fb[j]);
        len = n + HW;
        nout = (len + FW - 1) / FW;
        for (int i = 0; i < nout; i++) begin
            f.data = '0;
            for (int j = 0; j < FW; j++) begin
                idx = i * FW + j;
                if (idx < len) f.data[8*j +: 8] = s[idx];
            end
            f.eofc = (i == nout - 1) ? 8'(len - FW * i) : 8'd0;
            exp_q.push_back(f);
        end
        hdr_src.push_back(h);
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || hdr_src.size() != 0 || flit_src.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL %s timeout pending_out %0d pending_hdr %0d pending_flit %0d",
                     name, exp_q.size(), hdr_src.size(), flit_src.size());
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    // Header producer.
    initial begin : hdr_drv
        bit took;
        headerReady = 1'b0;
        headerData  = '0;
        forever begin
            if (!hold && rstn && hdr_src.size() > 0) begin
                headerReady = 1'b1;
                headerData  = hdr_src[0];
            end else begin
                headerReady = 1'b0;
            end
            @(negedge clk);
            took = headerReady && !headerStop && rstn;
            @(posedge clk);
            #1;
            if (took && hdr_src.size() > 0) void'(hdr_src.pop_front());
        end
    end

    // Flit producer.
    initial begin : flit_drv
        bit took;
        smiInReady = 1'b0;
        smiInEofc  = '0;
        smiInData  = '0;
        forever begin
            if (!hold && rstn && flit_src.size() > 0) begin
                smiInReady = 1'b1;
                smiInEofc  = flit_src[0].eofc;
                smiInData  = flit_src[0].data;
            end else begin
                smiInReady = 1'b0;
            end
            @(negedge clk);
            took = smiInReady && !smiInStop && rstn;
            @(posedge clk);
            #1;
            if (took && flit_src.size() > 0) void'(flit_src.pop_front());
        end
    end

    // Output backpressure.
    initial begin : stop_drv
        smiOutStop = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            smiOutStop = rand_stop ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every accepted output flit.
    initial begin : monitor
        flit_t e;
        logic [FW*8-1:0] m;
        forever begin
            @(negedge clk);
            if (rstn && smiOutReady && !smiOutStop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flit got eofc %0d data %h", smiOutEofc, smiOutData);
                end else begin
                    e = exp_q.pop_front();
                    m = '0;
                    if (e.eofc == 8'd0) m = '1;
                    else for (int j = 0; j < FW; j++) if (j < int'(e.eofc)) m[8*j +: 8] = 8'hFF;
                    if (smiOutEofc !== e.eofc || (smiOutData & m) !== (e.data & m)) begin
                        errors++;
                        $display("FAIL out_flit got eofc %0d data %h expected eofc %0d data %h",
                                 smiOutEofc, smiOutData, e.eofc, e.data);
                    end
                end
                seen_first = 1'b1;
            end else if (rstn && tput_mode && seen_first && exp_q.size() > 0 && !smiOutReady) begin
                gap_cnt++;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        flit_t f;
        rstn = 1'b0;
        #2;
        check("reset_out_ready", 128'(smiOutReady), 128'd0);
        check("reset_hdr_stop", 128'(headerStop), 128'd0);
        check("reset_in_stop", 128'(smiInStop), 128'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #2;

        // Short frame that fits with the header in one flit.
        hdr_src.push_back(32'hDDCCBBAA);
        f.eofc = 8'd8;
        f.data = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        flit_src.push_back(f);
        f.eofc = 8'd12;
        f.data = 128'h00000000_07060504_03020100_DDCCBBAA;
        exp_q.push_back(f);
        drain("single_flit", 50);

        // Frame overflowing into a tail flit.
        hdr_src.push_back(32'h44332211);
        f.eofc = 8'd14;
        f.data = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
        flit_src.push_back(f);
        f.eofc = 8'd0;
        f.data = 128'h1B1A1918_17161514_13121110_44332211;
        exp_q.push_back(f);
        f.eofc = 8'd2;
        f.data = 128'h00000000_00000000_00000000_00001D1C;
        exp_q.push_back(f);
        drain("tail_flit", 50);

        // Three full flits -> four output flits.
        fb.delete();
        for (int j = 0; j < 48; j++) fb.push_back(8'(8'h20 + j));
        add_frame(32'h88776655);
        drain("three_flit", 80);

        // Flit waits for a late header; nothing may be emitted meanwhile.
        f.eofc = 8'd3;
        f.data = 128'h5F5E5D5C_5B5A5958_57565554_53525150;
        flit_src.push_back(f);
        repeat (6) @(posedge clk);
        #2;
        check("late_hdr_in_stop", 128'(smiInStop), 128'd1);
        check("late_hdr_out_ready", 128'(smiOutReady), 128'd0);
        check("late_hdr_hdr_stop", 128'(headerStop), 128'd0);
        hdr_src.push_back(32'h0D0C0B0A);
        f.eofc = 8'd7;
        f.data = 128'h00000000_00525150_0D0C0B0A;
        exp_q.push_back(f);
        drain("late_header", 50);

        // Back-to-back frames with no backpressure must stream without gaps.
        tput_mode = 1'b1;
        seen_first = 1'b0;
        gap_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            fb.delete();
            for (int j = 0; j < 5 + 9 * k; j++) fb.push_back(8'($urandom));
            add_frame($urandom);
        end
        drain("throughput", 200);
        tput_mode = 1'b0;
        check("throughput_gaps", 128'(gap_cnt), 128'd0);

        // Random frames under random backpressure.
        rand_stop = 1'b1;
        for (int k = 0; k < 200; k++) begin
            fb.delete();
            for (int j = 0; j < $urandom_range(1, 50); j++) fb.push_back(8'($urandom));
            add_frame($urandom);
        end
        drain("random_frames", 20000);
        rand_stop = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // Reset in the middle of a frame.
        fb.delete();
        for (int j = 0; j < 48; j++) fb.push_back(8'($urandom));
        add_frame($urandom);
        repeat (4) @(posedge clk);
        #3;
        rstn = 1'b0;
        hold = 1'b1;
        headerReady = 1'b0;
        smiInReady = 1'b0;
        #1;
        check("midrst_out_ready", 128'(smiOutReady), 128'd0);
        check("midrst_hdr_stop", 128'(headerStop), 128'd0);
        check("midrst_in_stop", 128'(smiInStop), 128'd0);
        hdr_src.delete();
        flit_src.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #2;
        hold = 1'b0;
        fb.delete();
        for (int j = 0; j < 30; j++) fb.push_back(8'(8'h90 + j));
        add_frame(32'hA3A2A1A0);
        drain("after_reset", 80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/smi_header_inject_pf1.md
SMI_HEADER_INJECT_PF1 -- requirements
Module: smi_header_inject_pf1

Interface
REQ-001 SHALL have parameter FlitWidth, default 16, flit data width in bytes (power of two, 4..128).
REQ-002 SHALL have parameter HeadWidth, default 4, header width in bytes (1..FlitWidth-1).
REQ-003 SHALL derive FlitSplit = FlitWidth-HeadWidth and EofcMask = 2*FlitWidth-1 (not overridable).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 headerReady  input  1  header word valid.
REQ-007 headerData  input  HeadWidth*8  header to prepend to the next frame.
REQ-008 headerStop  output  1  header backpressure.
REQ-009 smiInReady  input  1  input flit valid.
REQ-010 smiInEofc  input  8  end-of-frame control: 0 = not last flit, else valid byte count (1..FlitWidth) of the last flit.
REQ-011 smiInData  input  FlitWidth*8  input flit data, byte 0 in bits [7:0].
REQ-012 smiInStop  output  1  input flit backpressure.
REQ-013 smiOutReady  output  1  output flit valid.
REQ-014 smiOutEofc  output  8  output end-of-frame control, same encoding as smiInEofc.
REQ-015 smiOutData  output  FlitWidth*8  output flit data.
REQ-016 smiOutStop  input  1  output backpressure.

Function
REQ-017 SHALL transfer a word on any port in a cycle where Ready=1 and Stop=0; a producer holds Ready and data stable while Stop=1.
REQ-018 SHALL register header and flit inputs in one-entry input stages; the stage Stop output = stage full AND halted; a full, non-halted stage reloads in the same cycle.
REQ-019 SHALL mask registered smiInEofc with EofcMask[7:0].
REQ-020 SHALL emit each output frame as: header in bytes 0..HeadWidth-1 of flit 0, then the input frame bytes in order, contiguous, with no gaps.
REQ-021 SHALL implement states IDLE, COPY, TAIL; reset state IDLE.
REQ-022 IDLE: SHALL wait until both the registered header and the registered flit are valid and the output buffer is not stopped, then consume both in the same cycle; SHALL NOT consume either one alone.
REQ-023 IDLE emit: data = {flit bytes 0..FlitSplit-1, header}; carry register <= flit bytes FlitSplit..FlitWidth-1; saved eofc <= flit eofc.
REQ-024 COPY emit, one output flit per consumed input flit: data = {flit bytes 0..FlitSplit-1, carry}; carry and saved eofc update as in REQ-023.
REQ-025 On a consumed flit with eofc e: e=0 -> output eofc 0, next state COPY; 1<=e<=FlitSplit -> output eofc e+HeadWidth, next IDLE; e>FlitSplit -> output eofc 0, next TAIL.
REQ-026 TAIL: SHALL consume no input; SHALL emit data = {zeros, carry} with eofc = saved eofc - FlitSplit; SHALL move to IDLE when the emit is accepted.
REQ-027 SHALL hold state, carry and saved eofc unchanged while the output buffer is stopped.
REQ-028 SHALL drive the output through a two-entry skid buffer; its Stop to the state machine SHALL be asserted only when both entries are full, and it SHALL lose and duplicate no flit.
REQ-029 Latency: input flit accepted at edge N -> corresponding output flit valid at smiOutReady after edge N+1, with no stalls.
REQ-030 SHALL sustain one output flit per cycle across consecutive frames when smiOutStop=0 and the header is valid in time.
REQ-031 SHALL NOT check eofc values greater than FlitWidth after masking; behaviour for such values is undefined.

Reset
REQ-032 rstn low SHALL asynchronously clear: state to IDLE, input-stage and output-buffer valid flags, and all Ready/Stop outputs to 0.
REQ-033 Data, carry and saved-eofc registers SHALL NOT be reset.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL be well formed.

Verification (FlitWidth=16, HeadWidth=4)
REQ-035 Header 0xDDCCBBAA + single flit bytes 00..0F, eofc 8 -> one flit, eofc 12, bytes AA BB CC DD 00..07.
REQ-036 Header H + single flit, eofc 14 -> flit A: eofc 0, {bytes 0..11, H}; flit B: eofc 2, bytes 0..1 = input bytes 12..13.
REQ-037 Three-flit frame, last eofc 16 -> four output flits, eofc 0,0,0,4; byte stream = H followed by 48 input bytes.
REQ-038 Flit valid with header absent for 5 cycles -> no output, smiInStop=1 after the input stage fills; header arrives -> frame emitted correctly.
REQ-039 Random smiOutStop toggling over 200 random frames -> output matches scoreboard exactly; throughput 1 flit/cycle when Stop=0.
REQ-040 rstn pulsed low mid-frame -> all Ready/Stop outputs 0 immediately; next frame correct.
